// File: rtl/trace_stream_logger.sv
// Packs 2**sel trace lanes into WIDTH-bit words and writes them to a circular memory, either as a
// triggered ring capture with a post-trigger window (TRACE) or as a trigger-gated FIFO (STREAM).
module trace_stream_logger #(
  parameter int WIDTH      = 32,
  parameter int MAX_TRACES = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SEL_BITS   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     config_update_i,
  input  logic                     mode_i,
  input  logic [SEL_BITS-1:0]      ntrace_sel_i,
  input  logic [ADDR_WIDTH-1:0]    delay_i,
  input  logic                     sample_en_i,
  input  logic                     trig_i,
  input  logic [MAX_TRACES-1:0]    trace_i,
  output logic                     write_o,
  input  logic                     write_allow_i,
  output logic [ADDR_WIDTH-1:0]    write_ptr_o,
  output logic [WIDTH-1:0]         dmem_o,
  output logic                     read_o,
  output logic [ADDR_WIDTH-1:0]    read_ptr_o,
  input  logic [WIDTH-1:0]         dmem_i,
  output logic [WIDTH-1:0]         stream_o,
  output logic                     stream_valid_o,
  input  logic                     stream_ready_i,
  output logic                     trig_event_o,
  output logic [ADDR_WIDTH-1:0]    event_ptr_o,
  output logic [$clog2(WIDTH)-1:0] event_pos_o,
  output logic                     done_o,
  output logic                     overflow_o,
  output logic [ADDR_WIDTH:0]      fill_o
);

  localparam int PW  = $clog2(WIDTH);
  localparam int PW1 = PW + 1;
  localparam int LW  = $clog2(MAX_TRACES);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = AW1'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_DONE   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  mode_q;
  logic [SEL_BITS-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0] delay_q;
  logic [PW-1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]      word_q, word_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]      pend_data_q, pend_data_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  rd_q, rd_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic                  trig_q, trig_d;
  logic [ADDR_WIDTH-1:0] eptr_q, eptr_d;
  logic [PW-1:0]         epos_q, epos_d;
  logic                  over_q, over_d;
  logic [ADDR_WIDTH:0]   left_q, left_d;

  logic [PW:0]        nlog_c;
  logic [PW:0]        nlanes_c;
  logic [PW:0]        spw_c;
  logic [PW-1:0]      last_idx_c;
  logic [PW-1:0]      pos_c;
  logic [WIDTH-1:0]   lane_mask_c;
  logic [WIDTH-1:0]   sample_c;
  logic [WIDTH-1:0]   word_next_c;
  logic               full_c;
  logic               empty_c;
  logic               write_c;
  logic               push_c;
  logic               out_valid_c;
  logic               read_c;
  logic               trig_hit_c;
  logic               store_c;
  logic               complete_c;
  logic [WIDTH-1:0]   stream_c;

  // Lane geometry: N = 2**sel capped at MAX_TRACES, S = WIDTH/N samples per word.
  always_comb begin
    if (int'(sel_q) > LW) begin
      nlog_c = PW1'(LW);
    end else begin
      nlog_c = PW1'(sel_q);
    end
    nlanes_c    = PW1'(1) << nlog_c;
    spw_c       = PW1'(WIDTH) >> nlog_c;
    last_idx_c  = PW'(spw_c - PW1'(1));
    pos_c       = idx_q << nlog_c;
    lane_mask_c = (WIDTH'(1) << nlanes_c) - WIDTH'(1);
    sample_c    = WIDTH'(trace_i) & lane_mask_c;
    word_next_c = (word_q & ~(lane_mask_c << pos_c)) | (sample_c << pos_c);
  end

  always_comb begin
    full_c      = (fill_q == DEPTH);
    empty_c     = (fill_q == '0);
    write_c     = pend_valid_q && write_allow_i && (state_q != ST_DONE) && !(mode_q && full_c);
    push_c      = write_c && mode_q;
    out_valid_c = rd_q || hold_valid_q;
    read_c      = mode_q && !empty_c && (!out_valid_c || stream_ready_i);
    trig_hit_c  = (state_q == ST_ARMED) && sample_en_i && trig_i;
    // STREAM/ARMED discards everything except the trigger sample itself.
    store_c     = sample_en_i && ((state_q == ST_POST) || (state_q == ST_STREAM) ||
                  ((state_q == ST_ARMED) && (!mode_q || trig_i)));
    complete_c  = store_c && (idx_q == last_idx_c);
    stream_c    = rd_q ? dmem_i : hold_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: begin
        if (trig_hit_c) begin
          state_d = mode_q ? ST_STREAM : ST_POST;
        end
      end
      ST_POST: begin
        if (write_c && (left_q == AW1'(1))) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    idx_d        = idx_q;
    word_d       = word_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    over_d       = over_q;
    if (write_c) begin
      pend_valid_d = 1'b0;
    end
    if (store_c) begin
      word_d = word_next_c;
      idx_d  = complete_c ? '0 : idx_q + PW'(1);
    end
    // A word completing while the previous one is still stuck is lost.
    if (complete_c) begin
      if (!pend_valid_q || write_c) begin
        pend_valid_d = 1'b1;
        pend_data_d  = word_next_c;
      end else begin
        over_d = 1'b1;
      end
    end
  end

  always_comb begin
    trig_d = trig_q;
    eptr_d = eptr_q;
    epos_d = epos_q;
    left_d = left_q;
    if (trig_hit_c) begin
      trig_d = 1'b1;
      eptr_d = wptr_q + ADDR_WIDTH'(pend_valid_q);
      epos_d = pos_c;
      // Writes still to come in POST: any older pending word, the trigger word, then DELAY more.
      left_d = {1'b0, delay_q} + AW1'(1) + AW1'(pend_valid_q && !write_c);
    end else if ((state_q == ST_POST) && write_c) begin
      left_d = left_q - AW1'(1);
    end
  end

  always_comb begin
    wptr_d       = write_c ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d       = read_c ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    rd_d         = read_c;
    hold_valid_d = out_valid_c && !stream_ready_i;
    hold_d       = (out_valid_c && !stream_ready_i) ? stream_c : hold_q;
    case ({push_c, read_c})
      2'b10:   fill_d = fill_q + AW1'(1);
      2'b01:   fill_d = fill_q - AW1'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q  <= 1'b0;
      sel_q   <= '0;
      delay_q <= '0;
    end else if (config_update_i) begin
      mode_q  <= mode_i;
      sel_q   <= ntrace_sel_i;
      delay_q <= delay_i;
    end
  end

  // Update restarts capture exactly like reset; only the config registers above differ.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || config_update_i) begin
      state_q      <= ST_ARMED;
      idx_q        <= '0;
      word_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      fill_q       <= '0;
      rd_q         <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      trig_q       <= 1'b0;
      eptr_q       <= '0;
      epos_q       <= '0;
      over_q       <= 1'b0;
      left_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fill_q       <= fill_d;
      rd_q         <= rd_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      trig_q       <= trig_d;
      eptr_q       <= eptr_d;
      epos_q       <= epos_d;
      over_q       <= over_d;
      left_q       <= left_d;
    end
  end

  assign write_o        = write_c;
  assign write_ptr_o    = wptr_q;
  assign dmem_o         = pend_data_q;
  assign read_o         = read_c;
  assign read_ptr_o     = rptr_q;
  assign stream_o       = stream_c;
  assign stream_valid_o = out_valid_c;
  assign trig_event_o   = trig_q;
  assign event_ptr_o    = eptr_q;
  assign event_pos_o    = epos_q;
  assign done_o         = (state_q == ST_DONE);
  assign overflow_o     = over_q;
  assign fill_o         = fill_q;

endmodule

// File: tb/tb_trace_stream_logger.sv
// Bench for trace_stream_logger: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference model of the logger.
module tb_trace_stream_logger;

  localparam int D = 8;
  localparam int PH_ARMED = 0, PH_POST = 1, PH_DONE = 2, PH_STREAM = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, upd, mode, se, trig, allow, ready;
  logic [1:0]  sel;
  logic [2:0]  delay;
  logic [7:0]  trace;
  logic [31:0] dmem_rd;

  logic        write_o, read_o, stream_valid, trig_event, done, overflow;
  logic [2:0]  write_ptr, read_ptr, event_ptr;
  logic [31:0] dmem_o, stream_o;
  logic [4:0]  event_pos;
  logic [3:0]  fill;

  logic [31:0] mem [D];

  trace_stream_logger #(.WIDTH(32), .MAX_TRACES(8), .ADDR_WIDTH(3), .SEL_BITS(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .config_update_i(upd), .mode_i(mode), .ntrace_sel_i(sel),
    .delay_i(delay), .sample_en_i(se), .trig_i(trig), .trace_i(trace), .write_o(write_o),
    .write_allow_i(allow), .write_ptr_o(write_ptr), .dmem_o(dmem_o), .read_o(read_o),
    .read_ptr_o(read_ptr), .dmem_i(dmem_rd), .stream_o(stream_o), .stream_valid_o(stream_valid),
    .stream_ready_i(ready), .trig_event_o(trig_event), .event_ptr_o(event_ptr),
    .event_pos_o(event_pos), .done_o(done), .overflow_o(overflow), .fill_o(fill)
  );

  // Memory with registered read.
  always @(posedge clk) begin
    if (write_o) mem[write_ptr] <= dmem_o;
    if (read_o) dmem_rd <= mem[read_ptr];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  int          m_mode, m_sel, m_delay, m_phase;
  logic [31:0] m_samp[$];
  logic [31:0] m_pend[$];
  logic [31:0] m_fifo[$];
  int          m_wptr, m_rptr, m_eptr, m_epos, m_left;
  bit          m_ov, m_trig, m_over;
  logic [31:0] m_od;

  task automatic model_reset();
    m_phase = PH_ARMED;
    m_samp.delete(); m_pend.delete(); m_fifo.delete();
    m_wptr = 0; m_rptr = 0; m_eptr = 0; m_epos = 0; m_left = 0;
    m_ov = 0; m_trig = 0; m_over = 0; m_od = '0;
  endtask

  function automatic bit exp_write();
    return (m_pend.size() != 0) && (allow === 1'b1) && (m_phase != PH_DONE) &&
           !(m_mode == 1 && m_fifo.size() == D);
  endfunction

  function automatic bit exp_read();
    return (m_mode == 1) && (m_fifo.size() != 0) && (!m_ov || ready === 1'b1);
  endfunction

  task automatic model_step();
    bit wr, rd, hit, st;
    int ph, n, pend_before, wptr_before;
    logic [31:0] w;
    if (!rst_n || upd) begin
      model_reset();
      m_mode = rst_n ? int'(mode) : 0;
      m_sel = rst_n ? int'(sel) : 0;
      m_delay = rst_n ? int'(delay) : 0;
      return;
    end
    wr = exp_write(); rd = exp_read();
    ph = m_phase; pend_before = m_pend.size(); wptr_before = m_wptr;
    n = 1 << m_sel;
    if (rd) begin
      m_od = m_fifo.pop_front(); m_ov = 1; m_rptr = (m_rptr + 1) % D;
    end else if (m_ov && ready) begin
      m_ov = 0;
    end
    if (wr) begin
      if (m_mode == 1) m_fifo.push_back(m_pend[0]);
      m_pend.delete();
      m_wptr = (m_wptr + 1) % D;
      if (ph == PH_POST) begin
        m_left--;
        if (m_left == 0) m_phase = PH_DONE;
      end
    end
    hit = (ph == PH_ARMED) && se && trig;
    st = se && (ph == PH_POST || ph == PH_STREAM || (ph == PH_ARMED && (m_mode == 0 || hit)));
    if (hit) begin
      m_trig = 1;
      m_epos = m_samp.size() * n;
      m_eptr = (wptr_before + pend_before) % D;
      m_left = m_delay + 1 + ((pend_before != 0 && !wr) ? 1 : 0);
      m_phase = (m_mode == 1) ? PH_STREAM : PH_POST;
    end
    if (st) begin
      m_samp.push_back(32'(trace) & ((32'd1 << n) - 32'd1));
      if (m_samp.size() == 32 / n) begin
        w = '0;
        foreach (m_samp[k]) w |= m_samp[k] << (k * n);
        m_samp.delete();
        if (m_pend.size() == 0) m_pend.push_back(w);
        else m_over = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit ew, er;
    ew = exp_write(); er = exp_read();
    check("write", write_o, ew);
    check("wptr", write_ptr, m_wptr);
    if (ew) check("wdata", dmem_o, m_pend[0]);
    check("read", read_o, er);
    check("rptr", read_ptr, m_rptr);
    check("svalid", stream_valid, m_ov);
    if (m_ov) check("sdata", stream_o, m_od);
    check("trig", trig_event, m_trig);
    check("eptr", event_ptr, m_eptr);
    check("epos", event_pos, m_epos);
    check("done", done, m_phase == PH_DONE);
    check("ovf", overflow, m_over);
    check("fill", fill, m_fifo.size());
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic m, input logic [1:0] s, input logic [2:0] d);
    upd = 1; mode = m; sel = s; delay = d; se = 0; trig = 0;
    tick();
    upd = 0;
  endtask

  int max_fill;

  initial begin
    rst_n = 0; upd = 0; mode = 0; sel = 0; delay = 0; se = 0; trig = 0; trace = 0;
    allow = 1; ready = 1;
    model_reset(); m_mode = 0; m_sel = 0; m_delay = 0;
    @(posedge clk); #1;
    tick();
    rst_n = 1;

    // T1: ring capture, trigger on sample 6, two post-trigger words.
    do_update(0, 2'd3, 3'd2);
    for (int i = 1; i <= 16; i++) begin
      se = 1; trace = 8'(i); trig = (i == 6);
      tick();
    end
    se = 0; trig = 0;
    repeat (3) tick();
    check("t1_eptr", event_ptr, 1);
    check("t1_epos", event_pos, 8);
    check("t1_word0", mem[0], 32'h04030201);
    check("t1_trigword", mem[1], 32'h08070605);
    check("t1_post1", mem[2], 32'h0C0B0A09);
    check("t1_post2", mem[3], 32'h100F0E0D);
    check("t1_done", done, 1);
    check("t1_wptr", write_ptr, 4);

    // T5: update together with trigger while in POST.
    do_update(0, 2'd2, 3'd5);
    for (int i = 1; i <= 10; i++) begin
      se = 1; trace = 8'($urandom); trig = (i == 3);
      tick();
    end
    upd = 1; mode = 1; sel = 2'd1; delay = 3'd0; se = 1; trig = 1; trace = 8'hff;
    tick();
    upd = 0; trig = 0;
    check("t5_trig", trig_event, 0);
    check("t5_wptr", write_ptr, 0);
    check("t5_rptr", read_ptr, 0);
    check("t5_done", done, 0);
    for (int i = 0; i < 20; i++) begin
      trace = 8'($urandom);
      tick();
    end
    check("t5_armed_discard", write_ptr, 0);
    trig = 1; tick(); trig = 0;
    check("t5_trig_after", trig_event, 1);
    check("t5_epos", event_pos, 0);

    // T2: stream into a stalled consumer until full and overflowing, then drain.
    do_update(1, 2'd0, 3'd0);
    ready = 0;
    for (int i = 0; i < 12 * 32; i++) begin
      se = 1; trig = (i == 0); trace = 8'($urandom);
      tick();
    end
    se = 0; trig = 0;
    check("t2_fill_full", fill, 8);
    check("t2_overflow", overflow, 1);
    ready = 1;
    repeat (30) tick();
    check("t2_drained", fill, 0);

    // T3: sustained input with an always-ready consumer.
    do_update(1, 2'd3, 3'd0);
    max_fill = 0;
    for (int i = 0; i < 200; i++) begin
      se = 1; trig = (i == 0); trace = 8'($urandom);
      tick();
      if (int'(fill) > max_fill) max_fill = int'(fill);
    end
    se = 0; trig = 0;
    check("t3_fill_max_le2", max_fill <= 2, 1);
    check("t3_no_overflow", overflow, 0);

    // T4: writes blocked across two word completions.
    do_update(0, 2'd3, 3'd0);
    allow = 0;
    for (int i = 1; i <= 8; i++) begin
      se = 1; trace = 8'(8'h10 + i);
      tick();
    end
    se = 0; allow = 1;
    repeat (3) tick();
    check("t4_overflow", overflow, 1);
    check("t4_first_word", mem[0], 32'h14131211);
    check("t4_wptr", write_ptr, 1);

    // T6: reset in the middle of streaming.
    do_update(1, 2'd3, 3'd0);
    ready = 0;
    for (int i = 0; i < 16; i++) begin
      se = 1; trig = (i == 0); trace = 8'($urandom);
      tick();
    end
    se = 0; trig = 0;
    tick();
    check("t6_fill3", fill, 3);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("t6_write", write_o, 0);
    check("t6_wptr", write_ptr, 0);
    check("t6_dmem", dmem_o, 0);
    check("t6_read", read_o, 0);
    check("t6_rptr", read_ptr, 0);
    check("t6_stream", stream_o, 0);
    check("t6_svalid", stream_valid, 0);
    check("t6_trig", trig_event, 0);
    check("t6_eptr", event_ptr, 0);
    check("t6_epos", event_pos, 0);
    check("t6_done", done, 0);
    check("t6_ovf", overflow, 0);
    check("t6_fill", fill, 0);

    // Random traffic under random configurations.
    for (int seg = 0; seg < 10; seg++) begin
      do_update(1'($urandom), 2'($urandom), 3'($urandom));
      for (int i = 0; i < 250; i++) begin
        rst_n = ($urandom_range(0, 199) != 0);
        se = ($urandom_range(0, 9) < 8);
        trig = ($urandom_range(0, 39) == 0);
        allow = ($urandom_range(0, 19) < 17);
        ready = 1'($urandom);
        trace = 8'($urandom);
        tick();
      end
      rst_n = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
